// File: rtl/nes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : nes_pkg                                                 |
// | Description : Shared constants for the NES controller poller: button  |
// |               width, button bit positions and FSM state encodings.    |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package nes_pkg;

  localparam int BUTTON_BITS = 8;

  // Bit positions inside one controller byte (first shifted bit in MSB).
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // Poller FSM state encodings.
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_COMMIT    = 3'd4;

endpackage : nes_pkg
`default_nettype wire

// File: rtl/nes_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : nes_edge_detect                                         |
// | Description : One controller's held-state register plus one-cycle     |
// |               pressed/released masks, loaded on a commit strobe.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module nes_edge_detect
  import nes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_commit,
  input  logic [BUTTON_BITS-1:0] i_capture,
  output logic [BUTTON_BITS-1:0] o_held,
  output logic [BUTTON_BITS-1:0] o_pressed,
  output logic [BUTTON_BITS-1:0] o_released
);

  logic [BUTTON_BITS-1:0] r_held;
  logic [BUTTON_BITS-1:0] r_pressed;
  logic [BUTTON_BITS-1:0] r_released;

  // On commit, compare the new capture against the held state; masks clear on every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held     <= '0;
      r_pressed  <= '0;
      r_released <= '0;
    end else if (i_commit) begin
      r_held     <= i_capture;
      r_pressed  <= i_capture & ~r_held;
      r_released <= ~i_capture & r_held;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
    end
  end

  assign o_held     = r_held;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;

endmodule : nes_edge_detect
`default_nettype wire

// File: rtl/nes_controller_poller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : nes_controller_poller                                   |
// | Description : Periodically triggers a controller fetch, waits for a   |
// |               fresh valid edge, and publishes held state plus         |
// |               pressed/released masks per controller.                  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module nes_controller_poller
  import nes_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 4,
  parameter int POLL_PERIOD     = 100000,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable_i,
  output logic                                 start_fetch_o,
  input  logic                                 valid_i,
  input  logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] data_LIST_i,
  output logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] buttons_LIST_o,
  output logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] pressed_LIST_o,
  output logic [BUTTON_BITS*NUM_CONTROLLERS-1:0] released_LIST_o,
  output logic                                 update_o,
  output logic                                 timeout_o
);

  localparam int C_PW = (POLL_PERIOD    > 1) ? $clog2(POLL_PERIOD)    : 1;
  localparam int C_WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int C_DW = BUTTON_BITS * NUM_CONTROLLERS;

  state_t            r_state;
  logic [C_PW-1:0]   r_period;
  logic [C_WW-1:0]   r_wait;
  logic [C_DW-1:0]   r_capture;
  logic              r_start;
  logic              r_update;
  logic              r_timeout;

  logic              w_tick;
  logic              w_wait_done;
  logic              w_commit;

  assign w_tick      = enable_i && (r_period == C_PW'(POLL_PERIOD - 1));
  assign w_wait_done = (r_wait == C_WW'(TIMEOUT_CYCLES - 1));
  assign w_commit    = (r_state == ST_COMMIT);

  // Free-running poll period counter: advances whenever enabled, independent of fetch progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (enable_i) begin
      if (w_tick) r_period <= '0;
      else        r_period <= r_period + 1'b1;
    end
  end

  // Fetch sequencer; a tick arriving while a fetch is in flight is dropped (no queued start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_capture <= '0;
      r_start   <= 1'b0;
      r_update  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_update  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_START;
            r_start <= 1'b1;
            r_wait  <= '0;
          end
        end
        // Wait counter reads 0 during START, so it equals cycles elapsed since the pulse.
        ST_START: begin
          r_state <= ST_WAIT_LOW;
          r_wait  <= r_wait + 1'b1;
        end
        // Must see valid drop first so a stale high valid is never captured.
        ST_WAIT_LOW: begin
          if (w_wait_done) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
            if (!valid_i) r_state <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (valid_i) begin
            r_capture <= data_LIST_i;
            r_state   <= ST_COMMIT;
          end else if (w_wait_done) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        // Edge slices load this cycle; a tick landing here starts the next fetch directly.
        ST_COMMIT: begin
          r_update <= 1'b1;
          if (w_tick) begin
            r_state <= ST_START;
            r_start <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_ctrl
    nes_edge_detect u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_commit   (w_commit),
      .i_capture  (r_capture[g*BUTTON_BITS +: BUTTON_BITS]),
      .o_held     (buttons_LIST_o[g*BUTTON_BITS +: BUTTON_BITS]),
      .o_pressed  (pressed_LIST_o[g*BUTTON_BITS +: BUTTON_BITS]),
      .o_released (released_LIST_o[g*BUTTON_BITS +: BUTTON_BITS])
    );
  end

  assign start_fetch_o = r_start;
  assign update_o      = r_update;
  assign timeout_o     = r_timeout;

endmodule : nes_controller_poller
`default_nettype wire

// File: tb/tb_nes_controller_poller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_nes_controller_poller                                |
// | Description : Directed bench for nes_controller_poller with a small   |
// |               behavioural controller-interface model.                 |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_nes_controller_poller;

  localparam int NC = 4;
  localparam int PP = 64;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        start_fetch_o;
  logic        valid_i;
  logic [31:0] data_LIST_i;
  logic [31:0] buttons_LIST_o;
  logic [31:0] pressed_LIST_o;
  logic [31:0] released_LIST_o;
  logic        update_o;
  logic        timeout_o;

  logic [31:0] model_data = '0;
  logic        stuck      = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  nes_controller_poller #(
    .NUM_CONTROLLERS (NC),
    .POLL_PERIOD     (PP),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .start_fetch_o   (start_fetch_o),
    .valid_i         (valid_i),
    .data_LIST_i     (data_LIST_i),
    .buttons_LIST_o  (buttons_LIST_o),
    .pressed_LIST_o  (pressed_LIST_o),
    .released_LIST_o (released_LIST_o),
    .update_o        (update_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk = ~clk;

  // Interface model: valid drops the cycle after start, stays low 8 cycles, rises with data.
  initial begin
    valid_i     = 1'b1;
    data_LIST_i = '0;
    forever begin
      @(posedge clk); #1;
      if (start_fetch_o && !stuck) begin
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        data_LIST_i = model_data;
        valid_i     = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wait_update(input string name);
    int n;
    n = 0;
    while (!update_o && n < 300) begin tick(); n++; end
    if (!update_o) begin
      n_vec++; n_err++;
      $display("FAIL %s: update_o not seen within 300 cycles", name);
    end
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!start_fetch_o && n < 300) begin tick(); n++; end
    if (!start_fetch_o) begin
      n_vec++; n_err++;
      $display("FAIL %s: start_fetch_o not seen within 300 cycles", name);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] buttons;
    logic [31:0] pressed;
    logic [31:0] released;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int starts[$];
    int n_upd;
    int first_start;
    int n;
    logic [31:0] old_v, new_v;

    tbl[0] = '{32'h8100_0000, 32'h8100_0000, 32'h8100_0000, 32'h0000_0000};
    tbl[1] = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 32'h8000_0000};
    tbl[2] = '{32'h01FF_0012, 32'h01FF_0012, 32'h00FF_0012, 32'h0000_0000};
    tbl[3] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0000, 32'h01FF_0010};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
    tbl[5] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000};

    // ---- Reset state ----
    rst_n    = 1'b0;
    enable_i = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {29'd0, start_fetch_o, update_o, timeout_o} | buttons_LIST_o | pressed_LIST_o | released_LIST_o,
          32'h0);

    // ---- Test 1: periodic starts with idle buttons ----
    @(posedge clk); #1; rst_n = 1'b1;
    n_upd = 0;
    for (int c = 1; c <= 210; c++) begin
      tick();
      if (start_fetch_o) starts.push_back(c);
      if (update_o) begin
        n_upd++;
        check("t1_edges_zero", pressed_LIST_o | released_LIST_o, 32'h0);
      end
    end
    check("t1_num_starts", starts.size(), 3);
    if (starts.size() == 3) begin
      check("t1_start0", starts[0], 64);
      check("t1_start1", starts[1], 128);
      check("t1_start2", starts[2], 192);
    end
    check("t1_num_updates", n_upd, 3);

    // ---- Test 2: edge-mask table ----
    for (int i = 0; i < 6; i++) begin
      model_data = tbl[i].data;
      tick();
      wait_update("t2_wait");
      check($sformatf("t2_buttons[%0d]", i),  buttons_LIST_o,  tbl[i].buttons);
      check($sformatf("t2_pressed[%0d]", i),  pressed_LIST_o,  tbl[i].pressed);
      check($sformatf("t2_released[%0d]", i), released_LIST_o, tbl[i].released);
      tick();
      check($sformatf("t2_pulse_end[%0d]", i),
            {31'd0, update_o} | pressed_LIST_o | released_LIST_o, 32'h0);
    end

    // ---- Test 3: valid stuck high -> timeout ----
    stuck = 1'b1;
    wait_start("t3_start");
    n = 0;
    n_upd = 0;
    while (!timeout_o && n < 100) begin
      tick(); n++;
      if (update_o) n_upd++;
    end
    check("t3_timeout_delay", n, TO);
    repeat (3) begin
      tick();
      if (update_o) n_upd++;
      check("t3_timeout_one_cycle", {31'd0, timeout_o}, 32'h0);
    end
    check("t3_no_update", n_upd, 0);
    check("t3_buttons_kept", buttons_LIST_o, 32'h1234_5678);
    stuck = 1'b0;

    // ---- Test 4: enable drop mid-fetch ----
    wait_start("t4_start");
    tick();
    enable_i = 1'b0;
    wait_update("t4_update");
    check("t4_update_seen", {31'd0, update_o}, 32'h1);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (start_fetch_o) n++;
    end
    check("t4_no_start_disabled", n, 0);
    enable_i = 1'b1;
    wait_start("t4_resume");
    model_data = 32'hA5A5_A5A5;
    wait_update("t4b_update");
    check("t4_buttons_a5", buttons_LIST_o, 32'hA5A5_A5A5);

    // ---- Test 5: async reset in WAIT_HIGH ----
    wait_start("t5_start");
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_reset_immediate",
          {29'd0, start_fetch_o, update_o, timeout_o} | buttons_LIST_o | pressed_LIST_o | released_LIST_o,
          32'h0);
    model_data = 32'h0;
    @(posedge clk); #1; rst_n = 1'b1;
    first_start = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (start_fetch_o && first_start < 0) first_start = c;
    end
    check("t5_first_start", first_start, 64);

    // ---- Test 6: sweep 0..255 on all controllers ----
    old_v = 32'h0;
    for (int v = 0; v < 256; v++) begin
      new_v      = {4{v[7:0]}};
      model_data = new_v;
      if (v > 0) tick();
      wait_update("t6_wait");
      check("t6_buttons", buttons_LIST_o, new_v);
      check("t6_xor", pressed_LIST_o ^ released_LIST_o, old_v ^ new_v);
      check("t6_pressed", pressed_LIST_o, new_v & ~old_v);
      old_v = new_v;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_nes_controller_poller
`default_nettype wire
